// File: rtl/mac_sequencer.sv
// Sequences operand pairs into an external MAC and collects one result per dot product.
// Define MAC_SEQ_RESULT_BUF_EN for a 2-entry result FIFO; otherwise a single result register.
module mac_sequencer #(
    parameter int unsigned A_WIDTH      = 16,
    parameter int unsigned B_WIDTH      = 16,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned LEN_WIDTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        vec_len,
    input  logic [LEN_WIDTH-1:0]        num_vec,
    output logic                        busy,
    output logic                        done,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic signed [A_WIDTH-1:0]   op_a,
    input  logic signed [B_WIDTH-1:0]   op_b,
    output logic                        mac_input_valid,
    output logic                        mac_accumulate_internal,
    output logic [A_WIDTH-1:0]          mac_a,
    output logic [B_WIDTH-1:0]          mac_b,
    input  logic [OUTPUT_WIDTH-1:0]     mac_out,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [OUTPUT_WIDTH-1:0]     res_data,
    output logic                        res_last
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e               state_q, state_d;
    logic [LEN_WIDTH-1:0] k_q, k_d;
    logic [LEN_WIDTH-1:0] n_q, n_d;
    logic [LEN_WIDTH-1:0] elem_cnt_q, elem_cnt_d;
    logic [LEN_WIDTH-1:0] vec_cnt_q, vec_cnt_d;
    logic                 done_q, done_d;

    logic op_fire;
    logic last_elem;
    logic last_vec;
    logic push;
    logic pop;
    logic stall;

    assign last_elem = (elem_cnt_q == k_q - LEN_WIDTH'(1));
    assign last_vec  = (vec_cnt_q == n_q - LEN_WIDTH'(1));

    assign op_ready                = (state_q == StRun) && !stall;
    assign op_fire                 = op_valid && op_ready;
    assign mac_input_valid         = op_fire;
    assign mac_a                   = op_a;
    assign mac_b                   = op_b;
    assign mac_accumulate_internal = (elem_cnt_q != '0);

    assign push = op_fire && last_elem;
    assign pop  = res_valid && res_ready;
    assign busy = (state_q != StIdle);
    assign done = done_q;

`ifdef MAC_SEQ_RESULT_BUF_EN
    logic [OUTPUT_WIDTH-1:0] buf_data_q [2];
    logic [1:0]              buf_last_q;
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              cnt_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
            end
            buf_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= mac_out;
                buf_last_q[wr_ptr_q] <= last_vec;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + 2'(push) - 2'(pop);
        end
    end

    assign res_valid = (cnt_q != '0);
    assign res_data  = buf_data_q[rd_ptr_q];
    assign res_last  = res_valid && buf_last_q[rd_ptr_q];
    // Only the closing element needs a free slot; a same-cycle pop does not count.
    assign stall     = last_elem && (cnt_q == 2'd2);
`else
    logic                    res_valid_q;
    logic [OUTPUT_WIDTH-1:0] res_data_q;
    logic                    res_last_q;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
        end else if (push) begin
            res_valid_q <= 1'b1;
            res_data_q  <= mac_out;
            res_last_q  <= last_vec;
        end else if (pop) begin
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_valid_q && res_last_q;
    assign stall     = res_valid_q;
`endif

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        n_d        = n_q;
        elem_cnt_d = elem_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        done_d     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && (vec_len != '0) && (num_vec != '0)) begin
                    k_d        = vec_len;
                    n_d        = num_vec;
                    elem_cnt_d = '0;
                    vec_cnt_d  = '0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (op_fire) begin
                    if (last_elem) begin
                        elem_cnt_d = '0;
                        vec_cnt_d  = vec_cnt_q + LEN_WIDTH'(1);
                        if (last_vec) begin
                            state_d = StDrain;
                        end
                    end else begin
                        elem_cnt_d = elem_cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if (pop && res_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state_q    <= StIdle;
            k_q        <= '0;
            n_q        <= '0;
            elem_cnt_q <= '0;
            vec_cnt_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            n_q        <= n_d;
            elem_cnt_q <= elem_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a behavioural MAC and a result scoreboard.
// Build with MAC_SEQ_RESULT_BUF_EN defined to exercise the buffered variant.
module tb_mac_sequencer;

    logic        clk;
    logic        rst_in;
    logic        start;
    logic [7:0]  vec_len;
    logic [7:0]  num_vec;
    logic        busy;
    logic        done;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        mac_input_valid;
    logic        mac_accumulate_internal;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic [15:0] mac_out;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_last;

    mac_sequencer dut (
        .clk                     (clk),
        .rst_in                  (rst_in),
        .start                   (start),
        .vec_len                 (vec_len),
        .num_vec                 (num_vec),
        .busy                    (busy),
        .done                    (done),
        .op_valid                (op_valid),
        .op_ready                (op_ready),
        .op_a                    (op_a),
        .op_b                    (op_b),
        .mac_input_valid         (mac_input_valid),
        .mac_accumulate_internal (mac_accumulate_internal),
        .mac_a                   (mac_a),
        .mac_b                   (mac_b),
        .mac_out                 (mac_out),
        .res_valid               (res_valid),
        .res_ready               (res_ready),
        .res_data                (res_data),
        .res_last                (res_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MAC: combinational result, accumulator updated on each valid input.
    logic [15:0] mac_acc;
    logic [31:0] prod;
    assign prod    = $signed(mac_a) * $signed(mac_b);
    assign mac_out = (mac_accumulate_internal ? mac_acc : 16'd0) + prod[15:0];
    always @(posedge clk) begin
        if (rst_in) mac_acc <= 16'd0;
        else if (mac_input_valid) mac_acc <= mac_out;
    end

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int hs_cyc = -100;
    int done_cnt = 0;
    logic done_prev = 1'b0;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor and done-pulse checker, sampled mid-low-phase.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (res_valid && res_ready && !rst_in) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got 0x%0h, required no result", res_data);
            end else begin
                e = sb.pop_front();
                check("res_data", {16'd0, res_data}, {16'd0, e.data});
                check("res_last", {31'd0, res_last}, {31'd0, e.last});
                if (res_last) hs_cyc = cyc;
            end
        end
        if (done) begin
            check("done_timing", cyc, hs_cyc + 1);
            check("done_width", {31'd0, done_prev}, 32'd0);
            check("done_idle", {31'd0, busy}, 32'd0);
            done_cnt++;
        end
        done_prev = done;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        op_valid = 1'b0;
        start    = 1'b0;
        #3;
        while (busy && n < 60) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (busy) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_start(input int kk, input int nn);
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (busy) check("start_wait_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
        op_valid = 1'b0;
        start    = 1'b1;
        vec_len  = kk[7:0];
        num_vec  = nn[7:0];
        @(negedge clk);
        start = 1'b0;
        #3;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("acc_first", {31'd0, mac_accumulate_internal}, 32'd0);
    endtask

    task automatic fire(input int a, input int b, input logic acc, input logic pu,
                        input int rd, input logic rl);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        op_valid = 1'b1;
        op_a     = a[15:0];
        op_b     = b[15:0];
        #3;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (!op_ready) check("op_ready_timeout", {31'd0, op_ready}, 32'd1);
        check("mac_valid", {31'd0, mac_input_valid}, 32'd1);
        check("mac_acc", {31'd0, mac_accumulate_internal}, {31'd0, acc});
        check("mac_a", {16'd0, mac_a}, {16'd0, a[15:0]});
        check("mac_b", {16'd0, mac_b}, {16'd0, b[15:0]});
        if (pu) begin
            e.data = rd[15:0];
            e.last = rl;
            sb.push_back(e);
        end
    endtask

    task automatic gap();
        @(negedge clk);
        op_valid = 1'b0;
        op_a     = 16'h7777;
        #3;
        check("gap_mac_valid", {31'd0, mac_input_valid}, 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_op_ready", {31'd0, op_ready}, 32'd0);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_last", {31'd0, res_last}, 32'd0);
        check("rst_res_data", {16'd0, res_data}, 32'd0);
        check("rst_acc", {31'd0, mac_accumulate_internal}, 32'd0);
    endtask

    typedef struct {
        logic st;
        int   k;
        int   n;
        logic vld;
        int   a;
        int   b;
        logic acc;
        logic push;
        int   res;
        logic last;
    } row_t;

    row_t tbl [14];

    initial begin
        int dc;
        // start rows: {1,K,N,...}; operand rows: {0,-,-,valid,a,b,exp_acc,push,exp_res,exp_last}
        tbl[0]  = '{1'b1, 3, 1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b0, 0, 0, 1'b1, 1, 2, 1'b0, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b0, 0, 0, 1'b1, 3, 4, 1'b1, 1'b0, 0, 1'b0};
        tbl[3]  = '{1'b0, 0, 0, 1'b1, 5, 6, 1'b1, 1'b1, 44, 1'b1};
        tbl[4]  = '{1'b1, 1, 3, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b0, 0, 0, 1'b1, 2, 3, 1'b0, 1'b1, 6, 1'b0};
        tbl[6]  = '{1'b0, 0, 0, 1'b1, 4, 5, 1'b0, 1'b1, 20, 1'b0};
        tbl[7]  = '{1'b0, 0, 0, 1'b1, -1, 7, 1'b0, 1'b1, -7, 1'b1};
        tbl[8]  = '{1'b1, 3, 1, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[9]  = '{1'b0, 0, 0, 1'b1, 2, 2, 1'b0, 1'b0, 0, 1'b0};
        tbl[10] = '{1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[11] = '{1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0};
        tbl[12] = '{1'b0, 0, 0, 1'b1, 3, 3, 1'b1, 1'b0, 0, 1'b0};
        tbl[13] = '{1'b0, 0, 0, 1'b1, 4, 4, 1'b1, 1'b1, 29, 1'b1};

        rst_in    = 1'b1;
        start     = 1'b0;
        vec_len   = 8'd0;
        num_vec   = 8'd0;
        op_valid  = 1'b0;
        op_a      = 16'd0;
        op_b      = 16'd0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_reset_outputs();
        @(negedge clk);
        rst_in = 1'b0;

        // Zero-length jobs are ignored.
        dc = done_cnt;
        @(negedge clk);
        start   = 1'b1;
        vec_len = 8'd0;
        num_vec = 8'd3;
        @(negedge clk);
        vec_len = 8'd2;
        num_vec = 8'd0;
        @(negedge clk);
        start = 1'b0;
        #3;
        check("zero_len_busy", {31'd0, busy}, 32'd0);
        check("zero_len_ready", {31'd0, op_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("zero_len_done", done_cnt, dc);

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].st) do_start(tbl[i].k, tbl[i].n);
            else if (tbl[i].vld) fire(tbl[i].a, tbl[i].b, tbl[i].acc, tbl[i].push,
                                      tbl[i].res, tbl[i].last);
            else gap();
        end
        wait_idle();

        // Backpressure with K=2, N=3.
        do_start(2, 3);
        @(negedge clk);
        res_ready = 1'b0;
        fire(1, 2, 1'b0, 1'b0, 0, 1'b0);
        fire(3, 4, 1'b1, 1'b1, 14, 1'b0);
`ifdef MAC_SEQ_RESULT_BUF_EN
        fire(5, 6, 1'b0, 1'b0, 0, 1'b0);
        fire(7, 8, 1'b1, 1'b1, 86, 1'b0);
        fire(1, 1, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_a     = 16'd1;
            op_b     = 16'd1;
            #3;
            check("stall_buf", {31'd0, op_ready}, 32'd0);
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data", {16'd0, res_data}, 32'd14);
        end
        @(negedge clk);
        res_ready = 1'b1;
        op_valid  = 1'b0;
        fire(1, 1, 1'b1, 1'b1, 2, 1'b1);
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_valid = 1'b1;
            op_a     = 16'd5;
            op_b     = 16'd6;
            #3;
            check("stall_nobuf", {31'd0, op_ready}, 32'd0);
            check("hold_valid", {31'd0, res_valid}, 32'd1);
            check("hold_data", {16'd0, res_data}, 32'd14);
        end
        @(negedge clk);
        res_ready = 1'b1;
        op_valid  = 1'b0;
        fire(5, 6, 1'b0, 1'b0, 0, 1'b0);
        fire(7, 8, 1'b1, 1'b1, 86, 1'b0);
        fire(1, 1, 1'b0, 1'b0, 0, 1'b0);
        fire(1, 1, 1'b1, 1'b1, 2, 1'b1);
`endif
        wait_idle();

        // Reset in the middle of a K=4 job, then a fresh job.
        do_start(4, 1);
        fire(1, 1, 1'b0, 1'b0, 0, 1'b0);
        fire(2, 2, 1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        op_valid = 1'b0;
        rst_in   = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        #3;
        check_reset_outputs();
        do_start(2, 1);
        // A start while busy must not reload K.
        @(negedge clk);
        start   = 1'b1;
        vec_len = 8'd1;
        num_vec = 8'd1;
        @(negedge clk);
        start = 1'b0;
        fire(1, 1, 1'b0, 1'b0, 0, 1'b0);
        fire(1, 1, 1'b1, 1'b1, 2, 1'b1);
        wait_idle();
        repeat (2) @(negedge clk);

        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter A_WIDTH, default 16, operand a width.
REQ-002 SHALL have parameter B_WIDTH, default 16, operand b width.
REQ-003 SHALL have parameter OUTPUT_WIDTH, default 16, MAC result width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8, width of the length and count fields.
REQ-005 SHALL have port clk  in  1  sole clock; one clock; all state on rising edge.
REQ-006 SHALL have port rst_in  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  in  1  job start request.
REQ-008 SHALL have port vec_len  in  LEN_WIDTH  elements per dot product (K), sampled on accepted start.
REQ-009 SHALL have port num_vec  in  LEN_WIDTH  dot products per job (N), sampled on accepted start.
REQ-010 SHALL have port busy  out  1  job in progress.
REQ-011 SHALL have port done  out  1  one-cycle job-complete pulse.
REQ-012 SHALL have ports op_valid in 1, op_ready out 1, op_a in A_WIDTH signed, op_b in B_WIDTH signed  operand stream.
REQ-013 SHALL have ports mac_input_valid out 1, mac_accumulate_internal out 1, mac_a out A_WIDTH, mac_b out B_WIDTH, mac_out in OUTPUT_WIDTH  MAC drive and return.
REQ-014 SHALL have ports res_valid out 1, res_ready in 1, res_data out OUTPUT_WIDTH, res_last out 1  result stream.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN; IDLE after reset.
REQ-016 IDLE: start=1 with vec_len!=0 and num_vec!=0 SHALL latch K and N, clear elem_cnt and vec_cnt, and go to RUN; otherwise start SHALL be ignored.
REQ-017 start while busy SHALL be ignored.
REQ-018 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-019 op_fire = op_valid & op_ready; op_ready SHALL be 0 outside RUN.
REQ-020 mac_a/mac_b SHALL equal op_a/op_b combinationally; mac_input_valid SHALL equal op_fire.
REQ-021 mac_accumulate_internal SHALL be 0 when elem_cnt==0, else 1.
REQ-022 On op_fire, elem_cnt SHALL increment; when elem_cnt==K-1 it SHALL wrap to 0, and vec_cnt SHALL increment.
REQ-023 When elem_cnt==K-1, op_fire SHALL push mac_out, unmodified, into result storage in the same cycle; res_valid SHALL assert the next cycle (latency 1).
REQ-024 res_last SHALL be 1 on the result of dot product N-1 and 0 otherwise.
REQ-025 Cycles with op_valid=0 SHALL not advance the counters or the MAC.
REQ-026 The push of the last element of dot product N-1 SHALL move the FSM RUN->DRAIN.
REQ-027 DRAIN: after the handshake of the res_last result, the FSM SHALL go to IDLE and pulse done for exactly one cycle, in the cycle after that handshake.
REQ-028 res_data/res_valid/res_last SHALL hold stable while res_valid=1 and res_ready=0.
REQ-029 Result storage capacity C SHALL be 1 without the configuration macro and 2 with it.
REQ-030 When elem_cnt==K-1 and storage holds C entries, op_ready SHALL be 0, even if a pop occurs in the same cycle (no pass-through).
REQ-031 With C=1 and a result pending, op_ready SHALL be 0 for all elements.
REQ-032 K=1 SHALL give mac_accumulate_internal=0 on every element, with one result per element.

Reset
REQ-033 rst_in=1 SHALL, at the next edge, force IDLE, clear counters, flush result storage, and drive busy, done, op_ready, res_valid, res_last and res_data to 0, including mid-job.
REQ-034 The first job after reset SHALL start with mac_accumulate_internal=0.

Configuration
REQ-035 Macro MAC_SEQ_RESULT_BUF_EN defined: 2-entry FIFO result storage, so the next dot product runs while a result awaits acceptance.
REQ-036 MAC_SEQ_RESULT_BUF_EN undefined: single result register; operand intake stalls while a result is pending.

Verification
REQ-037 K=3, N=1, ops (1,2),(3,4),(5,6), res_ready=1 -> accumulate 0,1,1; res_data=44, res_last=1; done pulses one cycle later.
REQ-038 K=1, N=3, ops (2,3),(4,5),(-1,7) -> results 6,20,-7; accumulate always 0; res_last only on -7.
REQ-039 K=2, N=3, res_ready=0 -> no buf: op_ready=0 after the first push; buf: two results held, op_ready=0 at element 1 of dot product 2.
REQ-040 start with vec_len=0 or num_vec=0 -> stays IDLE; busy=0; no done.
REQ-041 rst_in=1 after 2 of 4 elements -> next cycle all outputs 0; new job K=2, ops (1,1),(1,1) -> res_data=2.
REQ-042 op_valid toggled 1,0,0,1,1 with K=3 -> mac_input_valid=0 in gaps; exactly one result, after the third fire.
